// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - load-use stall and EX operand forwarding select controller
// Tracks destination info of in-flight instructions to drive forwarding selects and stalls.
module hazard_fwd_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   output logic              stall,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [CNT_W-1:0]  stall_cnt
);

   // The WB-resident writer is never consulted (write-first regfile), and a
   // load in MEM forwards like any writer, so only these fields are kept.
   logic              ex_valid_q, ex_valid_d;
   logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
   logic              ex_reg_write_q, ex_reg_write_d;
   logic              ex_mem_read_q, ex_mem_read_d;
   logic              mem_valid_q, mem_valid_d;
   logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
   logic              mem_reg_write_q, mem_reg_write_d;
   logic [1:0]        fwd_a_sel_q, fwd_a_sel_d;
   logic [1:0]        fwd_b_sel_q, fwd_b_sel_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic       ex_fwd, mem_fwd, ex_load;
   logic [1:0] sel_a, sel_b;

   always_comb begin
      ex_fwd  = ex_valid_q && ex_reg_write_q && (ex_dest_q != '0);
      mem_fwd = mem_valid_q && mem_reg_write_q && (mem_dest_q != '0);
      ex_load = id_valid && ex_fwd && ex_mem_read_q;

      stall = ex_load && !flush &&
              ((id_uses_rs && (id_rs == ex_dest_q)) ||
               (id_uses_rt && (id_rt == ex_dest_q)));

      sel_a = 2'b00;
      if (id_uses_rs && ex_fwd && (ex_dest_q == id_rs))
         sel_a = 2'b01;
      else if (id_uses_rs && mem_fwd && (mem_dest_q == id_rs))
         sel_a = 2'b10;

      sel_b = 2'b00;
      if (id_uses_rt && ex_fwd && (ex_dest_q == id_rt))
         sel_b = 2'b01;
      else if (id_uses_rt && mem_fwd && (mem_dest_q == id_rt))
         sel_b = 2'b10;
   end

   always_comb begin
      ex_valid_d      = ex_valid_q;
      ex_dest_d       = ex_dest_q;
      ex_reg_write_d  = ex_reg_write_q;
      ex_mem_read_d   = ex_mem_read_q;
      mem_valid_d     = mem_valid_q;
      mem_dest_d      = mem_dest_q;
      mem_reg_write_d = mem_reg_write_q;
      fwd_a_sel_d     = fwd_a_sel_q;
      fwd_b_sel_d     = fwd_b_sel_q;
      stall_cnt_d     = stall_cnt_q;

      if (!hold) begin
         mem_valid_d     = ex_valid_q;
         mem_dest_d      = ex_dest_q;
         mem_reg_write_d = ex_reg_write_q;

         if (flush || stall || !id_valid) begin
            ex_valid_d     = 1'b0;
            ex_dest_d      = '0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            fwd_a_sel_d    = 2'b00;
            fwd_b_sel_d    = 2'b00;
         end else begin
            ex_valid_d     = 1'b1;
            ex_dest_d      = id_dest;
            ex_reg_write_d = id_reg_write;
            ex_mem_read_d  = id_mem_read;
            fwd_a_sel_d    = sel_a;
            fwd_b_sel_d    = sel_b;
         end

         if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q      <= 1'b0;
         ex_dest_q       <= '0;
         ex_reg_write_q  <= 1'b0;
         ex_mem_read_q   <= 1'b0;
         mem_valid_q     <= 1'b0;
         mem_dest_q      <= '0;
         mem_reg_write_q <= 1'b0;
         fwd_a_sel_q     <= 2'b00;
         fwd_b_sel_q     <= 2'b00;
         stall_cnt_q     <= '0;
      end else begin
         ex_valid_q      <= ex_valid_d;
         ex_dest_q       <= ex_dest_d;
         ex_reg_write_q  <= ex_reg_write_d;
         ex_mem_read_q   <= ex_mem_read_d;
         mem_valid_q     <= mem_valid_d;
         mem_dest_q      <= mem_dest_d;
         mem_reg_write_q <= mem_reg_write_d;
         fwd_a_sel_q     <= fwd_a_sel_d;
         fwd_b_sel_q     <= fwd_b_sel_d;
         stall_cnt_q     <= stall_cnt_d;
      end
   end

   assign fwd_a_sel = fwd_a_sel_q;
   assign fwd_b_sel = fwd_b_sel_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - directed vector bench for hazard_fwd_ctrl
// Each vector: drive ID inputs, check comb stall, clock once, check selects and counter.
module tb_hazard_fwd_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hold = 1'b0;
   logic        flush = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs = '0;
   logic [4:0]  id_rt = '0;
   logic        id_uses_rs = 1'b0;
   logic        id_uses_rt = 1'b0;
   logic [4:0]  id_dest = '0;
   logic        id_reg_write = 1'b0;
   logic        id_mem_read = 1'b0;
   logic        stall;
   logic [1:0]  fwd_a_sel;
   logic [1:0]  fwd_b_sel;
   logic [15:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [4:0] rs;
      logic       urs;
      logic [4:0] rt;
      logic       urt;
      logic [4:0] dest;
      logic       rw;
      logic       mr;
      logic       fl;
      logic       hd;
      logic       e_stall;
      logic [1:0] e_a;
      logic [1:0] e_b;
      logic [15:0] e_cnt;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic iv, input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt, input logic [4:0] dest,
                               input logic rw, input logic mr, input logic fl, input logic hd,
                               input logic es, input logic [1:0] ea, input logic [1:0] eb,
                               input logic [15:0] ec);
      vec_t v;
      v.iv = iv; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.dest = dest;
      v.rw = rw; v.mr = mr; v.fl = fl; v.hd = hd;
      v.e_stall = es; v.e_a = ea; v.e_b = eb; v.e_cnt = ec;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step=%0d got=%0h exp=%0h", name, idx, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.iv; id_rs = v.rs; id_uses_rs = v.urs; id_rt = v.rt;
      id_uses_rt = v.urt; id_dest = v.dest; id_reg_write = v.rw;
      id_mem_read = v.mr; flush = v.fl; hold = v.hd;
   endtask

   initial begin
      //          iv rs urs rt urt dest rw mr fl hd | stall a b cnt
      vecs[0]  = mk(1, 1, 1,  2, 1,  5, 1, 0, 0, 0,  0, 0, 0, 0);
      vecs[1]  = mk(1, 5, 1,  3, 1,  6, 1, 0, 0, 0,  0, 1, 0, 0);
      vecs[2]  = mk(1, 1, 1,  2, 1,  7, 1, 0, 0, 0,  0, 0, 0, 0);
      vecs[3]  = mk(1, 0, 0,  0, 0,  7, 1, 0, 0, 0,  0, 0, 0, 0);
      vecs[4]  = mk(1, 4, 1,  7, 1,  8, 1, 0, 0, 0,  0, 0, 1, 0);
      vecs[5]  = mk(1, 0, 0,  0, 0,  7, 1, 0, 0, 0,  0, 0, 0, 0);
      vecs[6]  = mk(1, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
      vecs[7]  = mk(1, 0, 0,  7, 1, 10, 1, 0, 0, 0,  0, 0, 2, 0);
      vecs[8]  = mk(1, 0, 0,  0, 0,  9, 1, 1, 0, 0,  0, 0, 0, 0);
      vecs[9]  = mk(1, 9, 1, 10, 1, 11, 1, 0, 0, 0,  1, 0, 0, 1);
      vecs[10] = mk(1, 9, 1, 10, 1, 11, 1, 0, 0, 0,  0, 2, 0, 1);
      vecs[11] = mk(1, 0, 0,  0, 0,  0, 1, 1, 0, 0,  0, 0, 0, 1);
      vecs[12] = mk(1, 0, 1,  0, 1, 12, 1, 0, 0, 0,  0, 0, 0, 1);
      vecs[13] = mk(1, 0, 0,  0, 0, 13, 1, 1, 0, 0,  0, 0, 0, 1);
      vecs[14] = mk(1,13, 1, 12, 1,  0, 0, 0, 1, 0,  0, 0, 0, 1);
      vecs[15] = mk(1, 0, 0,  0, 0, 15, 1, 0, 0, 0,  0, 0, 0, 1);
      vecs[16] = mk(1,15, 1,  0, 0, 14, 1, 1, 0, 0,  0, 1, 0, 1);
      vecs[17] = mk(1,14, 1,  0, 0, 16, 1, 0, 0, 1,  1, 1, 0, 1);
      vecs[18] = mk(1,14, 1,  0, 0, 16, 1, 0, 0, 1,  1, 1, 0, 1);
      vecs[19] = mk(1,14, 1,  0, 0, 16, 1, 0, 0, 1,  1, 1, 0, 1);
      vecs[20] = mk(1,14, 1,  0, 0, 16, 1, 0, 0, 0,  1, 0, 0, 2);

      repeat (2) @(negedge clk);
      check("rst_stall", -1, 32'(stall), 32'd0);
      check("rst_a", -1, 32'(fwd_a_sel), 32'd0);
      check("rst_b", -1, 32'(fwd_b_sel), 32'd0);
      check("rst_cnt", -1, 32'(stall_cnt), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check("stall", i, 32'(stall), 32'(vecs[i].e_stall));
         @(posedge clk);
         #1;
         check("fwd_a", i, 32'(fwd_a_sel), 32'(vecs[i].e_a));
         check("fwd_b", i, 32'(fwd_b_sel), 32'(vecs[i].e_b));
         check("cnt", i, 32'(stall_cnt), 32'(vecs[i].e_cnt));
      end

      // Load r20 reading r14 (load in MEM) -> sel_b 10, then reset mid-stall
      @(negedge clk);
      drive(mk(1, 0, 0, 14, 1, 20, 1, 1, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check("ld_fwd_a", 100, 32'(fwd_a_sel), 32'd0);
      check("ld_fwd_b", 100, 32'(fwd_b_sel), 32'd2);
      check("ld_cnt", 100, 32'(stall_cnt), 32'd2);
      @(negedge clk);
      drive(mk(1, 20, 1, 0, 0, 21, 1, 0, 0, 1, 0, 0, 0, 0));
      #1;
      check("pre_rst_stall", 101, 32'(stall), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_stall", 102, 32'(stall), 32'd0);
      check("async_a", 102, 32'(fwd_a_sel), 32'd0);
      check("async_b", 102, 32'(fwd_b_sel), 32'd0);
      check("async_cnt", 102, 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hold = 1'b0;
      #1;
      check("post_rst_stall", 103, 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      check("post_rst_a", 103, 32'(fwd_a_sel), 32'd0);
      check("post_rst_cnt", 103, 32'(stall_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
